// File: rtl/conv_output_packer_if.sv
// Pixel-in / word-out bundle between the convolve stage, the packer and the host-side reader.
interface conv_output_packer_if #(
    parameter int BITS       = 9,
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic [BITS-1:0]  in_data;
    logic             clear;
    logic             rd_en;
    logic [31:0]      rd_data;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             frame_done;
    logic [15:0]      pixel_count;

    modport master (
        output in_valid, in_data, clear, rd_en,
        input  rd_data, empty, full, level, overflow, frame_done, pixel_count
    );

    modport slave (
        input  in_valid, in_data, clear, rd_en,
        output rd_data, empty, full, level, overflow, frame_done, pixel_count
    );
endinterface

// File: rtl/conv_output_packer.sv
// Clamps signed convolution results to 8-bit pixels, packs four per 32-bit word (lane 0 = LSB)
// and buffers the words in a show-ahead FIFO. BITS must be at least 9.
module conv_output_packer #(
    parameter int BITS         = 9,
    parameter int FRAME_PIXELS = 196,
    parameter int FIFO_DEPTH   = 8
) (
    input logic                clk,
    input logic                reset,
    conv_output_packer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [15:0]      LAST_IDX  = 16'(FRAME_PIXELS - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    logic [1:0]       lane_q, lane_d;
    logic [31:0]      shift_q, shift_d;
    logic [15:0]      count_q, count_d;
    logic             stage_vld_q, stage_vld_d;
    logic [31:0]      stage_word_q, stage_word_d;
    logic             frame_done_q, frame_done_d;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;

    logic        over_range;
    logic [7:0]  pix;
    logic [31:0] word_fill;
    logic        accept, eof, push_word;
    logic        fifo_empty, fifo_full, pop, wr_en, drop;

    generate
        if (BITS > 9) begin : g_wide
            assign over_range = |bus.in_data[BITS-2:8];
        end else begin : g_narrow
            assign over_range = 1'b0;
        end
    endgenerate

    always_comb begin
        pix = bus.in_data[7:0];
        if (bus.in_data[BITS-1]) begin
            pix = 8'h00;
        end else if (over_range) begin
            pix = 8'hFF;
        end
    end

    // The incoming pixel lands in the current lane; lanes above it are still zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_fill[8*gi +: 8] = (lane_q == 2'(gi)) ? pix : shift_q[8*gi +: 8];
        end
    endgenerate

    assign accept    = bus.in_valid && !bus.clear;
    assign eof       = accept && (count_q == LAST_IDX);
    assign push_word = accept && ((lane_q == 2'd3) || eof);

    always_comb begin
        lane_d       = lane_q;
        shift_d      = shift_q;
        count_d      = count_q;
        stage_vld_d  = push_word;
        stage_word_d = word_fill;
        frame_done_d = eof;
        if (bus.clear) begin
            lane_d  = 2'd0;
            shift_d = 32'd0;
            count_d = 16'd0;
        end else if (accept) begin
            if (push_word) begin
                lane_d  = 2'd0;
                shift_d = 32'd0;
            end else begin
                lane_d  = lane_q + 2'd1;
                shift_d = word_fill;
            end
            count_d = eof ? 16'd0 : count_q + 16'd1;
        end
    end

    // A staged word always reaches the FIFO next cycle, even across a clear.
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == DEPTH_LVL);
    assign pop        = bus.rd_en && !fifo_empty;
    assign wr_en      = stage_vld_q && (!fifo_full || pop);
    assign drop       = stage_vld_q && fifo_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q;
        overflow_d = overflow_q | drop;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (bus.clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q       <= 2'd0;
            shift_q      <= 32'd0;
            count_q      <= 16'd0;
            stage_vld_q  <= 1'b0;
            stage_word_q <= 32'd0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            stage_vld_q  <= stage_vld_d;
            stage_word_q <= stage_word_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= stage_word_q;
        end
    end

    assign bus.rd_data     = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign bus.empty       = fifo_empty;
    assign bus.full        = fifo_full;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.pixel_count = count_q;
endmodule

// File: tb/tb_conv_output_packer.sv
// Self-checking bench for conv_output_packer: clamp/pack table, frame flush, FIFO overflow,
// full-FIFO push+pop, clear and mid-stream reset, with a word scoreboard.
module tb_conv_output_packer;
    localparam int BITS  = 9;
    localparam int FRAME = 6;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_output_packer_if #(.BITS(BITS), .FIFO_DEPTH(DEPTH)) bus ();

    conv_output_packer #(
        .BITS(BITS), .FRAME_PIXELS(FRAME), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [3:0][BITS-1:0] pix;
        logic [31:0]          word;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;
    int words_made = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_word;
    int m_lane, m_count;
    bit m_ovf;

    always @(negedge clk) if (bus.frame_done === 1'b1) fd_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] clamp_ref(input logic [BITS-1:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) return 8'h00;
        if (s > 255) return 8'hFF;
        return s[7:0];
    endfunction

    task automatic model_clear();
        m_word = 32'd0; m_lane = 0; m_count = 0; m_ovf = 1'b0;
    endtask

    task automatic model_pixel(input logic [BITS-1:0] v, output bit done, output logic [31:0] w);
        m_word[8*m_lane +: 8] = clamp_ref(v);
        m_count++;
        done = 1'b0;
        w = m_word;
        if (m_lane == 3 || m_count == FRAME) begin
            done = 1'b1;
            m_word = 32'd0;
            m_lane = 0;
            if (m_count == FRAME) m_count = 0;
        end else begin
            m_lane++;
        end
    endtask

    task automatic send_pix(input logic [BITS-1:0] v);
        bit done;
        logic [31:0] w;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        model_pixel(v, done, w);
        if (done) begin
            words_made++;
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else m_ovf = 1'b1;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic read_word(input string name);
        logic [31:0] exp;
        check({name, " empty"}, 32'(bus.empty), 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %h, expected no word (scoreboard empty)", name, bus.rd_data);
        end else begin
            exp = exp_q.pop_front();
            check(name, bus.rd_data, exp);
            $display("read %s: %h", name, bus.rd_data);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.clear = 1'b0; bus.rd_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        words_made = 0;
    endtask

    initial begin
        vec_t vecs [3];
        int fd0;
        int v;
        bit done;
        logic [31:0] w;

        vecs[0] = '{pix: {9'h080, 9'h1FF, 9'h0FF, 9'h001}, word: 32'h8000FF01};
        vecs[1] = '{pix: {9'h0FF, 9'h000, 9'h1FF, 9'h100}, word: 32'hFF000000};
        vecs[2] = '{pix: {9'h0AA, 9'h1C0, 9'h0FE, 9'h07F}, word: 32'hAA00FE7F};

        // Reset state, observed while reset is still asserted
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 9'h033; bus.clear = 1'b0; bus.rd_en = 1'b0;
        tick();
        tick();
        check("rst rd_data", bus.rd_data, 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst level", 32'(bus.level), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        check("rst frame_done", 32'(bus.frame_done), 32'd0);
        check("rst pixel_count", 32'(bus.pixel_count), 32'd0);
        $display("reset state checked");

        // Clamp and lane packing table
        for (int i = 0; i < 3; i++) begin
            do_reset();
            for (int k = 0; k < 4; k++) send_pix(vecs[i].pix[k]);
            check($sformatf("vec%0d latency empty", i), 32'(bus.empty), 32'd1);
            tick();
            check($sformatf("vec%0d empty", i), 32'(bus.empty), 32'd0);
            check($sformatf("vec%0d level", i), 32'(bus.level), 32'd1);
            check($sformatf("vec%0d word", i), bus.rd_data, vecs[i].word);
            check($sformatf("vec%0d pixel_count", i), 32'(bus.pixel_count), 32'd4);
            $display("vector %0d: word %h", i, bus.rd_data);
        end

        // End of frame: partial word flushed, one frame_done pulse
        do_reset();
        fd0 = fd_count;
        for (int i = 0; i < FRAME; i++) begin
            send_pix(BITS'(17 + i));
            if (i == FRAME - 2) check("frame_done early", 32'(bus.frame_done), 32'd0);
        end
        check("frame_done pulse", 32'(bus.frame_done), 32'd1);
        check("frame pixel_count", 32'(bus.pixel_count), 32'd0);
        tick();
        check("frame_done drop", 32'(bus.frame_done), 32'd0);
        check("frame_done count", 32'(fd_count - fd0), 32'd1);
        check("frame level", 32'(bus.level), 32'd2);
        read_word("frame w0");
        read_word("frame w1");

        // Overflow: nine words into an eight-deep FIFO
        do_reset();
        v = 1;
        while (words_made < DEPTH + 1) begin
            send_pix(BITS'(v));
            v++;
        end
        tick();
        tick();
        check("ovf full", 32'(bus.full), 32'd1);
        check("ovf level", 32'(bus.level), 32'(DEPTH));
        check("ovf flag", 32'(bus.overflow), 32'(m_ovf));
        for (int i = 0; i < DEPTH; i++) read_word($sformatf("ovf w%0d", i));
        check("ovf drained empty", 32'(bus.empty), 32'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("underflow level", 32'(bus.level), 32'd0);
        check("underflow empty", 32'(bus.empty), 32'd1);
        check("ovf sticky", 32'(bus.overflow), 32'd1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
        check("clear ovf", 32'(bus.overflow), 32'd0);

        // Push coinciding with a pop on a full FIFO
        do_reset();
        v = 1;
        while (words_made < DEPTH) begin
            send_pix(BITS'(v));
            v++;
        end
        tick();
        tick();
        check("fullpop pre full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 3; i++) send_pix(BITS'(8'hC1 + i));
        bus.in_valid = 1'b1;
        bus.in_data  = 9'h0C4;
        model_pixel(9'h0C4, done, w);
        tick();
        bus.in_valid = 1'b0;
        bus.rd_en = 1'b1;
        check("fullpop head", bus.rd_data, exp_q[0]);
        tick();
        bus.rd_en = 1'b0;
        void'(exp_q.pop_front());
        if (done) exp_q.push_back(w);
        check("fullpop level", 32'(bus.level), 32'(DEPTH));
        check("fullpop full", 32'(bus.full), 32'd1);
        check("fullpop overflow", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) read_word($sformatf("fullpop w%0d", i));

        // clear mid-word discards the partial word and overrides in_valid
        do_reset();
        fd0 = fd_count;
        send_pix(9'h055);
        send_pix(9'h066);
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 9'h077;
        tick();
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        model_clear();
        check("clear pixel_count", 32'(bus.pixel_count), 32'd0);
        for (int i = 0; i < 4; i++) send_pix(BITS'(8'hA0 + i));
        tick();
        check("clear level", 32'(bus.level), 32'd1);
        check("clear pixel_count after", 32'(bus.pixel_count), 32'd4);
        read_word("clear word");
        check("clear no more words", 32'(bus.empty), 32'd1);
        check("clear no frame_done", 32'(fd_count - fd0), 32'd0);

        // Reset with three words buffered
        do_reset();
        v = 1;
        while (words_made < 3) begin
            send_pix(BITS'(v));
            v++;
        end
        tick();
        check("midrst level before", 32'(bus.level), 32'd3);
        reset = 1'b1;
        tick();
        check("midrst empty", 32'(bus.empty), 32'd1);
        check("midrst level", 32'(bus.level), 32'd0);
        check("midrst rd_data", bus.rd_data, 32'd0);
        reset = 1'b0;
        model_clear();
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_output_packer.md
Name: conv_output_packer

Overview:
- Downstream stage of the convolve block. Consumes its output_valid/img_output pixel stream.
- Clamps each signed result to an 8-bit unsigned pixel and packs four pixels into a 32-bit word.
- Buffers the words in a small show-ahead FIFO that the host/Wishbone side drains.
- Tracks pixels per frame, zero-pads and flushes the final partial word, and flags frame completion and overflow.

Parameters:
- BITS, 9, width of the incoming convolution result (two's complement signed).
- FRAME_PIXELS, 196, output pixels per frame (14x14 for a 16x16 image with a 3x3 kernel). Range 1..65535.
- FIFO_DEPTH, 8, number of 32-bit words in the FIFO. Must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel strobe; connects to convolve output_valid.
- in_data  input  BITS  signed pixel; connects to convolve img_output.
- clear  input  1  synchronous frame restart.
- rd_en  input  1  pop the head word.
- rd_data  output  32  head word of the FIFO (show-ahead).
- empty  output  1  FIFO holds no words.
- full  output  1  FIFO holds FIFO_DEPTH words.
- level  output  $clog2(FIFO_DEPTH)+1  number of words stored.
- overflow  output  1  sticky flag: a word was dropped.
- frame_done  output  1  one-cycle pulse when the last pixel of a frame has been packed.
- pixel_count  output  16  pixels accepted in the current frame.

Behaviour:
- Reset, while reset=1:
  - rd_data=0, empty=1, full=0, level=0, overflow=0, frame_done=0, pixel_count=0.
  - Packer lane index=0, shift register=0.
  - Reset mid-frame discards everything, including FIFO contents.
- Clamp (combinational on in_data, treated as signed BITS wide):
  - negative -> 0x00;
  - greater than 255 -> 0xFF;
  - otherwise the low 8 bits.
- Packing:
  - A pixel is accepted when in_valid=1 and clear=0.
  - The pixel is placed in lane k (k = 0..3) at bits [8k+7:8k]; lane 0 is the first pixel of the word (little-endian).
  - The lane index increments after each accepted pixel.
- Word push:
  - When lane 3 is written, the assembled word is pushed and the lane index returns to 0.
  - When the accepted pixel makes pixel_count reach FRAME_PIXELS, the word is pushed regardless of lane, with unfilled upper lanes zero.
  - At that point pixel_count returns to 0 and the lane index returns to 0 (end of frame).
  - frame_done is high the cycle after the end-of-frame pixel is accepted, for exactly one cycle.
- Latency: a pixel accepted on edge N that completes a word makes that word visible (empty=0, level incremented) after edge N+1. The path is one register stage from the packer into the FIFO.
- FIFO:
  - rd_data always shows the oldest word while empty=0; it is 0 while empty=1.
  - rd_en with empty=0 pops on the edge.
  - rd_en with empty=1 is ignored: no underflow, level unchanged.
  - Push with full=0: word stored.
  - Push with full=1 and no pop that cycle: word dropped, overflow set to 1 and held until reset or clear. FIFO contents are unchanged.
  - Push and pop in the same cycle, any level including full: both take effect, level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH. Level arithmetic must not alias between full and empty.
- clear (synchronous, overrides in_valid that cycle):
  - Zeros the lane index, the partial word, pixel_count and overflow.
  - The partial word is discarded, not pushed.
  - FIFO contents and the pop in that cycle are unaffected.
  - A word already staged for push the previous cycle still completes its push.
  - No frame_done is produced.
- in_valid high continuously is allowed: one pixel per cycle, no backpressure to convolve. Loss is visible only via overflow.
- An in_data value while in_valid=0 is ignored.

Test Plan:
- Reset, then 4 valid pixels 0x001, 0x0FF, 0x1FF(-1), 0x080 -> one cycle after the 4th: empty=0, level=1, rd_data=0x8000FF01.
- Negative clamp: pixels -256, -1, 0, 255 -> word 0xFF000000.
- FRAME_PIXELS=6, 6 pixels 0x11..0x16 -> two words 0x14131211 and 0x00001615; frame_done pulses once, one cycle after the 6th pixel; pixel_count returns to 0.
- FIFO_DEPTH=8, push 9 words with no reads -> full=1, level=8, overflow=1. Reading 8 words returns words 1..8 in order; word 9 is lost; rd_en on empty leaves level=0.
- Full FIFO: a word push coinciding with rd_en -> level stays 8, overflow stays 0, the popped word is the oldest, and the new word appears last.
- Assert clear after 2 pixels, then send 4 pixels 0xA0..0xA3 -> exactly one word 0xA3A2A1A0, no frame_done. Reset asserted mid-stream with 3 words buffered -> empty=1, level=0 the next cycle.
